// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } div_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {R,Q} left, subtract divisor if it fits.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem_i,
  input  logic [DIV_WIDTH-1:0] quo_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic [DIV_WIDTH:0]   rem_o,
  output logic [DIV_WIDTH-1:0] quo_o
);

  logic [DIV_WIDTH:0]   rem_sh;
  logic [DIV_WIDTH+1:0] trial;
  logic                 fits;

  always_comb begin
    rem_sh = {rem_i[DIV_WIDTH-1:0], quo_i[DIV_WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, divisor_i};
    // A set bit shifted out of R means the shifted value certainly exceeds the divisor.
    fits   = rem_i[DIV_WIDTH] | ~trial[DIV_WIDTH+1];
    if (fits) begin
      rem_o = trial[DIV_WIDTH:0];
      quo_o = {quo_i[DIV_WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh;
      quo_o = {quo_i[DIV_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div32_iter.sv
// Iterative 32-bit DIV/DIVU/REM/REMU, one restoring step per cycle, start/done handshake.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration.
module div32_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  div_state_e       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  div_op_e          op_q, op_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             is_signed;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             unused_rem_msb;

  div_step u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  assign unused_rem_msb = rem_q[WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    done_d    = 1'b0;
    result_d  = result_q;
    is_signed = ~op_q[0];
    a_neg     = is_signed & quo_q[WIDTH-1];
    b_neg     = is_signed & dvs_q[WIDTH-1];
    b_zero    = (dvs_q == '0);
    quo_fix   = negq_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = negr_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Raw operands parked in the quotient/divisor registers until PREP.
          op_d    = div_op_e'(op);
          quo_d   = operand_a;
          dvs_d   = operand_b;
          cnt_d   = '0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        quo_d   = is_signed ? abs_val(quo_q) : quo_q;
        dvs_d   = is_signed ? abs_val(dvs_q) : dvs_q;
        rem_d   = '0;
        negq_d  = (a_neg ^ b_neg) & ~b_zero;
        negr_d  = a_neg;
        cnt_d   = '0;
        state_d = S_ITER;
`ifdef DIV_EARLY_OUT_EN
        if (b_zero) begin
          quo_d   = '1;
          rem_d   = {1'b0, quo_q};
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          state_d = S_FIX;
        end else if (is_signed && quo_q == {1'b1, {(WIDTH-1){1'b0}}} && dvs_q == '1) begin
          quo_d   = {1'b1, {(WIDTH-1){1'b0}}};
          rem_d   = '0;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          state_d = S_FIX;
        end
`endif
      end
      S_ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITERS - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = op_q[1] ? rem_fix : quo_fix;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_DIV;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div32_iter.sv
// Directed self-checking bench for div32_iter: vector table plus multi-cycle corner sequences.
module tb_div32_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  div32_iter #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'h0) return 2;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`endif
    return 34;
  endfunction

  // Issues one op right now (start sampled at the next edge E0), then waits for done.
  // With interfere set, a different start is presented so that it is sampled at E0+5.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit interfere);
    int          cycles;
    bit          busy_bad;
    logic [31:0] res_before;
    res_before = result;
    op         = o;
    operand_a  = a;
    operand_b  = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cycles   = 0;
    busy_bad = 1'b0;
    chk({name, ".busy_after_start"}, {31'b0, busy}, 32'd1);
    chk({name, ".done_low_after_start"}, {31'b0, done}, 32'd0);
    while (!done && cycles < 60) begin
      if (interfere && cycles == 4) begin
        op        = 2'd1;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        start     = 1'b1;
      end else if (interfere && cycles == 5) begin
        start = 1'b0;
      end
      if (result !== res_before) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
      if (!done && !busy) busy_bad = 1'b1;
    end
    chk({name, ".done_seen"}, {31'b0, done}, 32'd1);
    chk({name, ".latency"}, cycles, exp_latency(o, a, b));
    chk({name, ".busy_in_done"}, {31'b0, busy}, 32'd0);
    chk({name, ".busy_hold_result_stable"}, {31'b0, busy_bad}, 32'd0);
    chk({name, ".result"}, result, exp);
  endtask

  initial begin
    int n;
    bit done_seen;

    vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1};
    vecs[5]  = '{2'd0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF};
    vecs[6]  = '{2'd1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF};
    vecs[7]  = '{2'd2, 32'h1234_5678,  32'd0,          32'h1234_5678};
    vecs[8]  = '{2'd3, 32'h1234_5678,  32'd0,          32'h1234_5678};
    vecs[9]  = '{2'd0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
    vecs[10] = '{2'd2, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
    vecs[11] = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[12] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    vecs[13] = '{2'd0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2};
    vecs[14] = '{2'd2, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE};
    vecs[15] = '{2'd1, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF};

    rst       = 1'b1;
    start     = 1'b0;
    op        = 2'd0;
    operand_a = '0;
    operand_b = '0;
    #1;
    chk("reset.busy", {31'b0, busy}, 32'd0);
    chk("reset.done", {31'b0, done}, 32'd0);
    chk("reset.result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Each op is issued in the done cycle of the previous one (back-to-back).
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
    end

    run_op("ignored_start", 2'd1, 32'd100, 32'd7, 32'd14, 1'b1);
    run_op("after_ignored", 2'd3, 32'd1000, 32'd3, 32'd1, 1'b0);

    // Abort during the 10th ITER cycle (edges E0+2.. are ITER, so after E0+11).
    op        = 2'd1;
    operand_a = 32'd123456;
    operand_b = 32'd10;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort.busy", {31'b0, busy}, 32'd0);
    chk("abort.done", {31'b0, done}, 32'd0);
    chk("abort.result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen = 1'b1;
      n++;
    end
    chk("abort.no_done_or_busy", {31'b0, done_seen}, 32'd0);
    run_op("post_abort", 2'd1, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div32_iter.md
# div32_iter

Iterative 32-bit integer divider for the RV32M execute stage; the sequential counterpart of the combinational multiplier datapath. It implements DIV, DIVU, REM and REMU with one radix-2 restoring step per cycle behind a start/done handshake. The core control issues one operation, stalls on `busy`, and captures `result` on `done`. Results follow the RISC-V M-extension rules, including the divide-by-zero and overflow cases.

## Interface
- `WIDTH`, 32: operand and result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU; sampled with `start`.
- `operand_a`  in  WIDTH  dividend; sampled with `start`.
- `operand_b`  in  WIDTH  divisor; sampled with `start`.
- `busy`  out  1  operation in flight; `start` is ignored while high.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  WIDTH  quotient or remainder; held until the next `done`.
- Reset and clock: one clock; reset is asynchronous and active-high.

## Operation
- FSM states and transitions:
  - IDLE → PREP on `start`.
  - PREP → ITER.
  - ITER, 32 cycles counted by a 5-bit counter, → FIX.
  - FIX → IDLE.
- PREP:
  - Latch `op`.
  - For signed ops (0, 2): take the absolute values of both operands as unsigned 32-bit. |0x80000000| = 0x80000000.
  - Record `neg_q` = sign(a) XOR sign(b), forced to 0 when b==0.
  - Record `neg_r` = sign(a).
- ITER step, using a 33-bit partial remainder R and a 32-bit quotient Q:
  - Shift {R,Q} left by 1.
  - Trial = R − divisor.
  - If Trial ≥ 0: R = Trial and Q[0] = 1; otherwise Q[0] = 0.
- FIX:
  - Quotient = `neg_q` ? −Q : Q.
  - Remainder = `neg_r` ? −R[31:0] : R[31:0].
  - Select by `op`, register into `result`, assert `done`.
- Boundary results:
  - Divide by zero: quotient is 0xFFFFFFFF, remainder is the dividend. This falls out of the iteration together with the `neg_q` forcing rule.
  - Overflow 0x80000000 / 0xFFFFFFFF (DIV): quotient 0x80000000, remainder 0. This falls out of the unsigned magnitude path.
- `start` while `busy`=1: ignored, with no effect on the current operation.
- Reset values: `busy`=0, `done`=0, `result`=0, FSM in IDLE, counter 0.
- Reset asserted mid-operation aborts the operation immediately; no `done` is produced.

## Timing
- `start` is sampled at edge E0.
- `busy` is high from after E0 until after E0+34.
- `done` is high for exactly the one cycle after edge E0+34 (PREP 1 + ITER 32 + FIX 1 = 34 edges), and `busy` is low in that same cycle.
- A `start` presented in the `done` cycle is accepted, giving back-to-back throughput of one operation per 34 cycles.
- `result` changes only on the edge that raises `done`.

## Configuration
- `DIV_EARLY_OUT_EN`:
  - Defined: PREP detects b==0 and the signed-overflow pattern, goes directly to FIX with the architectural result, and raises `done` after E0+2.
  - Undefined: every operation takes the full 34-cycle path, with identical results.

## Structure
- Package `div_pkg` holds:
  - `div_op_e` enum (DIV, DIVU, REM, REMU)
  - `div_state_e` enum (IDLE, PREP, ITER, FIX)
  - `DIV_WIDTH`=32 and `DIV_ITERS`=32 constants
- One sub-module, `div_step`: combinational single restoring iteration. Inputs: R, Q, divisor. Outputs: next R, next Q.

## Test plan
- DIVU 100/7 → 14; REMU 100/7 → 2. `done` occurs exactly once, after edge E0+34; `busy` is low in the `done` cycle.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. REM 7/0xFFFFFFFE → 1.
- Divide by zero:
  - DIV and DIVU 0x12345678/0 → 0xFFFFFFFF; REM → 0x12345678.
  - DIV 0xFFFFFFFB/0 → 0xFFFFFFFF; REM → 0xFFFFFFFB.
  - Latency is 2 edges with `DIV_EARLY_OUT_EN` defined and 34 without.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Second `start` at E0+5 with different operands: ignored, and the first result is unchanged. A new `start` in the `done` cycle is accepted and completes correctly.
- `rst` pulsed during the 10th ITER cycle:
  - `busy`, `done` and `result` all read 0 immediately.
  - No `done` follows.
  - A subsequent DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF.
